note_key_arbiter: RTL
=====================

Name: note_key_arbiter

Overview:
- Sits between the PS/2 scan-code receiver and the sine tone generator.
- Parses the make/break/extended byte sequences and tracks the note keys currently held.
- Drives `codigo` to the generator using last-note priority (monophonic), and asserts `note_on` so the output stage can mute when no note key is held.

Parameters:
- DEPTH, 4: held-key stack entries (2..8).
- TIMEOUT, 100000: clk cycles a prefix state (after F0/E0) may wait for the next byte before the parser aborts to IDLE.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- scan_code  in  8  byte from the PS/2 receiver.
- scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle.
- codigo  out  8  scan code of the sounding note; 8'h00 when none.
- note_on  out  1  high while at least one note key is held.
- held_count  out  $clog2(DEPTH+1)  number of stack entries in use.
- overflow  out  1  one-cycle pulse when a push evicts the oldest entry.

Behaviour:
- Reset (synchronous, wins over scan_valid in the same cycle):
  - codigo=8'h00, note_on=0, held_count=0, overflow=0.
  - Parser goes to IDLE; all stack slots are cleared to 8'h00.
- Parser FSM has four states: IDLE, BRK, EXT, EXT_BRK. Transitions happen only on a cycle with scan_valid=1.
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make event, stay in IDLE.
  - BRK: E0 -> EXT_BRK; any other byte is a break event -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is discarded (extended keys are not notes) -> IDLE.
  - EXT_BRK: any byte is discarded -> IDLE.
- Prefix timeout:
  - A counter clears on every scan_valid and counts while the parser is in BRK, EXT or EXT_BRK.
  - When it reaches TIMEOUT-1, the parser returns to IDLE with no event.
  - The counter saturates and is held at 0 in IDLE.
- Note filter: only the 24 note codes are acted on: 15 1D 24 2D 2C 35 3C 43 44 4D 1C 1B 23 2B 34 33 3B 42 4B 22 21 2A 32 31. Make or break events for any other code are ignored.
- Stack layout: slot[0] is the oldest entry; the top is slot[held_count-1].
- Make event:
  - Code already in the stack (typematic repeat): no change.
  - Else if held_count<DEPTH: write the code to slot[held_count] and increment held_count.
  - Else (full): shift slots down by one (slot[0] is lost), write the code to slot[DEPTH-1], held_count unchanged, pulse overflow.
- Break event:
  - Code in the stack at index i: slots i+1..top shift down by one, held_count decrements, and the vacated slot is cleared.
  - Code not in the stack: no change.
  - Removal completes in a single cycle.
- Outputs are registered:
  - codigo = slot[held_count-1] when held_count>0, else 8'h00.
  - note_on = (held_count!=0).
  - Both update on the clock edge after the scan_valid that completes the event; latency is 1 cycle.
- Only one event can occur per cycle, because scan_valid carries a single byte, so there are no simultaneous push/pop cases.
- A scan_valid arriving while overflow is pulsing is processed normally.

Decomposition:
- Shared package `kbd_pkg`:
  - Parser state enum (IDLE/BRK/EXT/EXT_BRK).
  - Constants KC_BREAK=8'hF0 and KC_EXT=8'hE0.
  - Function is_note_code(byte) holding the 24-code list, so the tone-step table and this block stay consistent.
- One natural sub-module: `held_key_stack`, covering search, push, evict-push and compacting remove, plus the top/count outputs.
- The parser FSM and the timeout counter stay in the top module.

Test Plan:
- Reset mid-sequence: send F0, then assert reset for 1 cycle, then send 1C -> 1C is treated as a make; codigo=1C, note_on=1, held_count=1.
- Last-note priority: make 1C, make 1B, make 23 -> codigo=23, held_count=3. Then break 1B (F0 1B) -> codigo stays 23, held_count=2. Then break 23 -> codigo=1C.
- Typematic repeat and non-note codes: make 15 five times, then make 5A -> held_count=1, codigo=15. Then break 5A -> no change. Then break 15 -> codigo=00, note_on=0.
- Extended keys: E0 75 and E0 F0 75 while 1D is held -> codigo=1D, held_count=1 throughout, parser back in IDLE.
- Overflow with DEPTH=4: make 15 1D 24 2D 2C -> overflow pulses exactly once, held_count=4, codigo=2C. Then break 15 -> no change, because 15 was evicted.
- Timeout with TIMEOUT=16: send F0, wait 20 cycles, send 1C -> 1C is treated as a make (codigo=1C), not a break.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared keyboard definitions: parser states, PS/2 prefix bytes and the
// note-key code list used by both this arbiter and the tone-step table.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parser_state_e;

  localparam logic [7:0] KC_BREAK = 8'hF0;
  localparam logic [7:0] KC_EXT   = 8'hE0;

  // The 24 scan codes that map to notes; anything else is not a note key.
  function automatic logic is_note_code(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    case (code)
      8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
      8'h44, 8'h4D, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33,
      8'h3B, 8'h42, 8'h4B, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/held_key_stack.sv
// Stack of held note keys, oldest in slot 0. Handles typematic-repeat
// suppression, push, evict-oldest push when full, and single-cycle
// compacting removal. Outputs are registered from the next-state stack so
// they move on the same edge as the stack itself.
module held_key_stack #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    key,
  output logic [7:0]    top_code,
  output logic          not_empty,
  output logic [CW-1:0] held_count,
  output logic          overflow
);

  logic [7:0]    slot_q [DEPTH];
  logic [7:0]    slot_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    top_q, top_d;
  logic          on_q, on_d;
  logic          ovf_q, ovf_d;
  logic          hit;
  logic [CW-1:0] hit_idx;

  // Locate the key among the live entries (first match; codes are unique).
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && (CW'(i) < count_q) && (slot_q[i] == key)) begin
        hit     = 1'b1;
        hit_idx = CW'(i);
      end
    end
  end

  // Next stack contents, count and overflow pulse for this cycle's event.
  // Slots above the top are always zero, so a compacting shift that pulls
  // in the slot above the top naturally clears the vacated entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_d[i] = slot_q[i];
    count_d = count_q;
    ovf_d   = 1'b0;
    if (push && !hit) begin
      if (count_q < CW'(DEPTH)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == count_q) slot_d[i] = key;
        end
        count_d = count_q + 1'b1;
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i + 1];
        slot_d[DEPTH-1] = key;
        ovf_d           = 1'b1;
      end
    end else if (pop && hit) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (CW'(i) >= hit_idx) slot_d[i] = slot_q[i + 1];
      end
      slot_d[DEPTH-1] = 8'h00;
      count_d         = count_q - 1'b1;
    end
  end

  // Sounding note is the newest entry of the next-state stack.
  always_comb begin
    top_d = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == count_d) top_d = slot_d[i];
    end
    on_d = (count_d != '0);
  end

  // Stack and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= 8'h00;
      count_q <= '0;
      top_q   <= 8'h00;
      on_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      count_q <= count_d;
      top_q   <= top_d;
      on_q    <= on_d;
      ovf_q   <= ovf_d;
    end
  end

  assign top_code   = top_q;
  assign not_empty  = on_q;
  assign held_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: rtl/note_key_arbiter.sv
// PS/2 make/break parser feeding a last-note-priority held-key stack.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting for a byte; plain byte is a make event
// ST_BRK     | F0 seen; next plain byte is a break event
// ST_EXT     | E0 seen; next byte is an extended key (ignored)
// ST_EXT_BRK | E0 F0 or F0 E0 seen; next byte is ignored
//
// Prefix states abort to ST_IDLE when no byte arrives for TIMEOUT cycles.
module note_key_arbiter #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 100000,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    scan_code,
  input  logic          scan_valid,
  output logic [7:0]    codigo,
  output logic          note_on,
  output logic [CW-1:0] held_count,
  output logic          overflow
);

  import kbd_pkg::*;

  localparam int            TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TC = TW'(TIMEOUT - 1);

  parser_state_e state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          make_evt, break_evt;

  // Parser state and prefix timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state: bytes drive the FSM; a silent prefix expires back to idle.
  always_comb begin
    state_d = state_q;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == KC_BREAK)    state_d = ST_BRK;
          else if (scan_code == KC_EXT) state_d = ST_EXT;
        end
        ST_BRK:     state_d = (scan_code == KC_EXT)   ? ST_EXT_BRK : ST_IDLE;
        ST_EXT:     state_d = (scan_code == KC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && (tmo_q == TC)) begin
      state_d = ST_IDLE;
    end
  end

  // Prefix timer: restarts on every byte, runs only in prefix states, saturates.
  always_comb begin
    tmo_d = tmo_q;
    if (scan_valid || (state_q == ST_IDLE)) tmo_d = '0;
    else if (tmo_q != TC)                   tmo_d = tmo_q + 1'b1;
  end

  // Event decode: only note codes produce stack operations.
  always_comb begin
    make_evt  = 1'b0;
    break_evt = 1'b0;
    if (scan_valid && is_note_code(scan_code)) begin
      make_evt  = (state_q == ST_IDLE);
      break_evt = (state_q == ST_BRK);
    end
  end

  held_key_stack #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_stack (
    .clk        (clk),
    .reset      (reset),
    .push       (make_evt),
    .pop        (break_evt),
    .key        (scan_code),
    .top_code   (codigo),
    .not_empty  (note_on),
    .held_count (held_count),
    .overflow   (overflow)
  );

endmodule
